// File: rtl/y86_seq_controller.sv
// Stage sequencer and PC owner for a sequential Y86-64 core: walks each instruction
// through F/D/E/M/W/PCUPD, skips unused stages, and tracks status and counters.
module y86_seq_controller #(
  parameter logic [63:0] PC_RESET    = 64'h0,
  parameter int          MEM_TIMEOUT = 15,
  parameter int          CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_icode,
  input  logic             i_instr_valid,
  input  logic             i_imem_error,
  input  logic             i_mem_ready,
  input  logic             i_dmem_error,
  input  logic             i_cnd,
  input  logic [63:0]      i_valc,
  input  logic [63:0]      i_valm,
  input  logic [63:0]      i_valp,
  output logic [63:0]      o_pc,
  output logic [5:0]       o_stage_en,
  output logic             o_mem_req,
  output logic [2:0]       o_stat,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_retired,
  output logic [CNT_W-1:0] o_cycles
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_EXECUTE   = 3'd3;
  localparam logic [2:0] ST_MEMORY    = 3'd4;
  localparam logic [2:0] ST_WRITEBACK = 3'd5;
  localparam logic [2:0] ST_PCUPD     = 3'd6;
  localparam logic [2:0] ST_HALTED    = 3'd7;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam int            TW      = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIM = TW'(MEM_TIMEOUT);
  localparam logic [TW-1:0] TMO_ONE = TW'(1);

  logic [2:0]       r_state;
  logic [3:0]       r_icode;
  logic [TW-1:0]    r_tmo;
  logic [63:0]      r_pc;
  logic [2:0]       r_stat;
  logic [5:0]       r_stage_en;
  logic             r_mem_req;
  logic             r_busy;
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_cycles;

  logic [2:0]       w_state_nxt;
  logic [3:0]       w_icode_nxt;
  logic [TW-1:0]    w_tmo_nxt;
  logic [TW-1:0]    w_tmo_inc;
  logic [63:0]      w_pc_nxt;
  logic [2:0]       w_stat_nxt;

  function automatic logic [5:0] f_stage(input logic [2:0] st);
    case (st)
      ST_FETCH:     f_stage = 6'b000001;
      ST_DECODE:    f_stage = 6'b000010;
      ST_EXECUTE:   f_stage = 6'b000100;
      ST_MEMORY:    f_stage = 6'b001000;
      ST_WRITEBACK: f_stage = 6'b010000;
      ST_PCUPD:     f_stage = 6'b100000;
      default:      f_stage = 6'b000000;
    endcase
  endfunction

  function automatic logic f_busy(input logic [2:0] st);
    f_busy = (st != ST_IDLE) && (st != ST_HALTED);
  endfunction

  assign w_tmo_inc = r_tmo + TMO_ONE;

  // Next-state, status, timeout and PC selection
  always_comb begin
    w_state_nxt = r_state;
    w_icode_nxt = r_icode;
    w_tmo_nxt   = r_tmo;
    w_pc_nxt    = r_pc;
    w_stat_nxt  = r_stat;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
        w_icode_nxt = i_icode;
        if (i_imem_error) begin
          w_stat_nxt  = STAT_ADR;
          w_state_nxt = ST_HALTED;
        end else if (!i_instr_valid || (i_icode > 4'hB)) begin
          w_stat_nxt  = STAT_INS;
          w_state_nxt = ST_HALTED;
        end else if (i_icode == 4'h0) begin
          w_stat_nxt  = STAT_HLT;
          w_state_nxt = ST_HALTED;
        end else begin
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: w_state_nxt = ST_EXECUTE;
      ST_EXECUTE: begin
        w_tmo_nxt = {TW{1'b0}};
        case (r_icode)
          4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: w_state_nxt = ST_MEMORY;
          4'h2, 4'h3, 4'h6:                   w_state_nxt = ST_WRITEBACK;
          default:                            w_state_nxt = ST_PCUPD;
        endcase
      end
      // A response on the last allowed cycle takes priority over the timeout
      ST_MEMORY: begin
        if (i_mem_ready) begin
          if (i_dmem_error) begin
            w_stat_nxt  = STAT_ADR;
            w_state_nxt = ST_HALTED;
          end else if (r_icode != 4'h4) begin
            w_state_nxt = ST_WRITEBACK;
          end else begin
            w_state_nxt = ST_PCUPD;
          end
        end else if (w_tmo_inc == TMO_LIM) begin
          w_stat_nxt  = STAT_ADR;
          w_state_nxt = ST_HALTED;
        end else begin
          w_tmo_nxt   = w_tmo_inc;
          w_state_nxt = ST_MEMORY;
        end
      end
      ST_WRITEBACK: w_state_nxt = ST_PCUPD;
      ST_PCUPD: begin
        if (((r_icode == 4'h7) && i_cnd) || (r_icode == 4'h8)) begin
          w_pc_nxt = i_valc;
        end else if (r_icode == 4'h9) begin
          w_pc_nxt = i_valm;
        end else begin
          w_pc_nxt = i_valp;
        end
        w_state_nxt = ST_FETCH;
      end
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State, PC, status and Moore outputs decoded from the upcoming state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_icode    <= 4'h0;
      r_tmo      <= {TW{1'b0}};
      r_pc       <= PC_RESET;
      r_stat     <= STAT_AOK;
      r_stage_en <= 6'b000000;
      r_mem_req  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_icode    <= w_icode_nxt;
      r_tmo      <= w_tmo_nxt;
      r_pc       <= w_pc_nxt;
      r_stat     <= w_stat_nxt;
      r_stage_en <= f_stage(w_state_nxt);
      r_mem_req  <= (w_state_nxt == ST_MEMORY);
      r_busy     <= f_busy(w_state_nxt);
    end
  end

  // Retired (wrapping) and busy-cycle (saturating) counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_retired <= {CNT_W{1'b0}};
      r_cycles  <= {CNT_W{1'b0}};
    end else begin
      if (r_state == ST_PCUPD) begin
        r_retired <= r_retired + CNT_W'(1);
      end
      if (r_busy && (r_cycles != {CNT_W{1'b1}})) begin
        r_cycles <= r_cycles + CNT_W'(1);
      end
    end
  end

  assign o_pc       = r_pc;
  assign o_stage_en = r_stage_en;
  assign o_mem_req  = r_mem_req;
  assign o_stat     = r_stat;
  assign o_busy     = r_busy;
  assign o_retired  = r_retired;
  assign o_cycles   = r_cycles;

endmodule
